// File: rtl/mdu_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
// Holds the FSM state encoding, the operation codes and default widths.
// Imported by mul_div_unit; contains no logic.
package mdu_pkg;

    // Default operand width and register address width
    localparam int MDU_WIDTH = 32;
    localparam int MDU_AW    = 4;

    // Operation select encodings; bit 1 selects divide, bit 0 selects the
    // upper half of the shared accumulator (MULHI product / REMU remainder)
    localparam logic [1:0] OP_MULLO = 2'b00;
    localparam logic [1:0] OP_MULHI = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide: shift-add multiply, restoring divide.
// Latency WIDTH+1 cycles from accept to Done (1 cycle for divide by zero).
// No queueing: Start is only honoured in IDLE and ignored while Busy.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int AW    = MDU_AW
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [AW-1:0]    DR_in,
    output logic             Busy,
    output logic             Done,
    output logic             RegW,
    output logic [AW-1:0]    DR,
    output logic [WIDTH-1:0] Reg_in
);

    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;

    // Shared datapath: acc is {product-high, multiplier} during multiply and
    // {partial remainder, dividend/quotient} during divide; opnd holds the
    // multiplicand or divisor for the whole operation.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   opnd;
    logic [1:0]         op_q;
    logic [AW-1:0]      dr_q;

    logic               div_zero;
    logic               calc_last;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   zero_result;

    // Divide by zero is detected on the live inputs so it can skip CALC
    assign div_zero    = Op[1] && (OpB == '0);
    assign calc_last   = (cnt == CNT_LAST);
    // DIVU by zero yields all ones, REMU by zero yields the dividend
    assign zero_result = Op[0] ? OpA : '1;

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt = div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (calc_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state; the write enable is the Done pulse
    always_comb begin
        Busy = (state != IDLE);
        Done = (state == DONE);
        RegW = (state == DONE);
    end

    // One iteration of the shared datapath
    always_comb begin
        // Multiply: conditionally add multiplicand to the upper half, then
        // shift the whole accumulator right, keeping the carry bit.
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // Divide: shift remainder left bringing in the next dividend bit,
        // subtract the divisor when it fits (restoring form).
        rem_sh  = acc[2*WIDTH-1:WIDTH-1];
        div_ge  = (rem_sh >= {1'b0, opnd});
        acc_nxt = acc;
        if (op_q[1]) begin
            if (div_ge) begin
                acc_nxt = {WIDTH'(rem_sh - {1'b0, opnd}), acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        end
        // Low half is MULLO product or quotient, high half MULHI or remainder
        result = op_q[0] ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
    end

    // Operand capture, iteration counter and result/destination registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            acc    <= '0;
            opnd   <= '0;
            op_q   <= '0;
            dr_q   <= '0;
            cnt    <= '0;
            Reg_in <= '0;
            DR     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_q <= Op;
                        dr_q <= DR_in;
                        acc  <= {{WIDTH{1'b0}}, OpA};
                        opnd <= OpB;
                        cnt  <= '0;
                        if (div_zero) begin
                            Reg_in <= zero_result;
                            DR     <= DR_in;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    if (calc_last) begin
                        cnt    <= '0;
                        Reg_in <= result;
                        DR     <= dr_q;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at WIDTH=32, AW=4.
// Cycle k is counted from the accepting rising edge; outputs sampled on negedge.
// Inputs are driven on the falling edge so setup is never ambiguous.
module tb_mul_div_unit;

    logic        CLK;
    logic        RESET;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic [3:0]  DR_in;
    logic        Busy;
    logic        Done;
    logic        RegW;
    logic [3:0]  DR;
    logic [31:0] Reg_in;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(32), .AW(4)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .Start  (Start),
        .Op     (Op),
        .OpA    (OpA),
        .OpB    (OpB),
        .DR_in  (DR_in),
        .Busy   (Busy),
        .Done   (Done),
        .RegW   (RegW),
        .DR     (DR),
        .Reg_in (Reg_in)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Issue one operation from a falling edge and wait (bounded) for Done.
    // Operand inputs are scrambled after acceptance to prove they were latched.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] dr, output int done_cyc, output int busy_cyc,
                          output logic [31:0] res, output logic [3:0] dr_o, output logic regw_o);
        Op = op; OpA = a; OpB = b; DR_in = dr; Start = 1'b1;
        done_cyc = -1; busy_cyc = 0; res = 'x; dr_o = 'x; regw_o = 1'b0;
        @(posedge CLK);
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (Busy) busy_cyc++;
            if (k == 1) begin
                Start = 1'b0; Op = ~op; OpA = ~a; OpB = ~b; DR_in = ~dr;
            end
            if (Done) begin
                done_cyc = k; res = Reg_in; dr_o = DR; regw_o = RegW;
                break;
            end
        end
        Start = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b0; Start = 1'b0; Op = 2'b00; OpA = '0; OpB = '0; DR_in = '0;
        repeat (3) @(negedge CLK);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
        checks++; if (RegW !== 1'b0) begin errors++; $display("FAIL reset_regw: got %b want 0", RegW); end
        checks++; if (DR !== 4'd0) begin errors++; $display("FAIL reset_dr: got %0d want 0", DR); end
        checks++; if (Reg_in !== 32'd0) begin errors++; $display("FAIL reset_reg_in: got %h want 0", Reg_in); end
        RESET = 1'b1;
    endtask

    task automatic test_mullo;
        int dc, bc; logic [31:0] r; logic [3:0] d; logic w;
        run_op(2'b00, 32'd7, 32'd6, 4'd3, dc, bc, r, d, w);
        checks++; if (dc !== 33) begin errors++; $display("FAIL mullo_latency: got %0d want 33", dc); end
        checks++; if (r !== 32'h0000_002A) begin errors++; $display("FAIL mullo_result: got %h want 0000002a", r); end
        checks++; if (d !== 4'd3) begin errors++; $display("FAIL mullo_dr: got %0d want 3", d); end
        checks++; if (w !== 1'b1) begin errors++; $display("FAIL mullo_regw: got %b want 1", w); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL mullo_busy_cycles: got %0d want 33", bc); end
        @(negedge CLK);
        checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL mullo_after_done: got done=%b busy=%b want 0 0", Done, Busy); end
        checks++; if (Reg_in !== 32'h0000_002A || DR !== 4'd3) begin errors++; $display("FAIL mullo_hold: got %h/%0d want 0000002a/3", Reg_in, DR); end
    endtask

    task automatic test_mul_wide;
        int dc, bc; logic [31:0] r; logic [3:0] d; logic w;
        @(negedge CLK);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, dc, bc, r, d, w);
        checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhi_max: got %h want fffffffe", r); end
        checks++; if (d !== 4'd5) begin errors++; $display("FAIL mulhi_dr: got %0d want 5", d); end
        @(negedge CLK);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, dc, bc, r, d, w);
        checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL mullo_max: got %h want 00000001", r); end
        @(negedge CLK);
        run_op(2'b01, 32'h8000_0000, 32'h0000_0004, 4'd7, dc, bc, r, d, w);
        checks++; if (r !== 32'h0000_0002) begin errors++; $display("FAIL mulhi_shift: got %h want 00000002", r); end
    endtask

    task automatic test_div;
        int dc, bc; logic [31:0] r; logic [3:0] d; logic w;
        @(negedge CLK);
        run_op(2'b10, 32'd100, 32'd7, 4'd9, dc, bc, r, d, w);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_result: got %0d want 14", r); end
        checks++; if (dc !== 33) begin errors++; $display("FAIL divu_latency: got %0d want 33", dc); end
        @(negedge CLK);
        run_op(2'b11, 32'd100, 32'd7, 4'd10, dc, bc, r, d, w);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_result: got %0d want 2", r); end
        checks++; if (dc !== 33) begin errors++; $display("FAIL remu_latency: got %0d want 33", dc); end
        @(negedge CLK);
        run_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 4'd11, dc, bc, r, d, w);
        checks++; if (r !== 32'h0FFF_FFFF) begin errors++; $display("FAIL divu_big: got %h want 0fffffff", r); end
        @(negedge CLK);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 4'd11, dc, bc, r, d, w);
        checks++; if (r !== 32'h0000_000F) begin errors++; $display("FAIL remu_big: got %h want 0000000f", r); end
    endtask

    task automatic test_div_zero;
        int dc, bc; logic [31:0] r; logic [3:0] d; logic w;
        @(negedge CLK);
        run_op(2'b10, 32'h1234, 32'h0, 4'd12, dc, bc, r, d, w);
        checks++; if (dc !== 1) begin errors++; $display("FAIL divzero_latency: got %0d want 1", dc); end
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divzero_result: got %h want ffffffff", r); end
        checks++; if (d !== 4'd12) begin errors++; $display("FAIL divzero_dr: got %0d want 12", d); end
        @(negedge CLK);
        run_op(2'b11, 32'h1234, 32'h0, 4'd13, dc, bc, r, d, w);
        checks++; if (r !== 32'h0000_1234) begin errors++; $display("FAIL remzero_result: got %h want 00001234", r); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL remzero_latency: got %0d want 1", dc); end
    endtask

    task automatic test_start_ignored;
        int dones = 0;
        int first_dc = -1;
        logic [31:0] first_r = '0;
        @(negedge CLK);
        Op = 2'b00; OpA = 32'd7; OpB = 32'd6; DR_in = 4'd2; Start = 1'b1;
        @(posedge CLK);
        for (int k = 1; k <= 80; k++) begin
            @(negedge CLK);
            if (k == 1) Start = 1'b0;
            if (k == 5) begin Start = 1'b1; OpA = 32'd99; end
            if (k == 6) Start = 1'b0;
            if (first_dc > 0 && k == first_dc + 1) Start = 1'b0;
            if (Done) begin
                dones++;
                if (first_dc < 0) begin
                    first_dc = k; first_r = Reg_in;
                    Start = 1'b1;  // raised in DONE, dropped before IDLE
                end
            end
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
        checks++; if (first_r !== 32'd42) begin errors++; $display("FAIL ignore_result: got %0d want 42", first_r); end
        checks++; if (first_dc !== 33) begin errors++; $display("FAIL ignore_latency: got %0d want 33", first_dc); end
    endtask

    task automatic test_back_to_back;
        int dc, bc; logic [31:0] r; logic [3:0] d; logic w;
        @(negedge CLK);
        run_op(2'b00, 32'd9, 32'd9, 4'd1, dc, bc, r, d, w);
        checks++; if (r !== 32'd81) begin errors++; $display("FAIL b2b_first: got %0d want 81", r); end
        @(negedge CLK);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%b want 0", Busy); end
        run_op(2'b10, 32'd100, 32'd7, 4'd4, dc, bc, r, d, w);
        checks++; if (r !== 32'd14 || d !== 4'd4) begin errors++; $display("FAIL b2b_second: got %0d/%0d want 14/4", r, d); end
        checks++; if (dc !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", dc); end
    endtask

    task automatic test_reset_mid;
        int dc, bc; logic [31:0] r; logic [3:0] d; logic w;
        @(negedge CLK);
        Op = 2'b00; OpA = 32'hDEAD_BEEF; OpB = 32'h1234_5678; DR_in = 4'd8; Start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        repeat (9) @(negedge CLK);
        RESET = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL midreset_status: got busy=%b done=%b want 0 0", Busy, Done); end
        checks++; if (Reg_in !== 32'd0 || DR !== 4'd0) begin errors++; $display("FAIL midreset_outputs: got %h/%0d want 0/0", Reg_in, DR); end
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        run_op(2'b00, 32'd3, 32'd5, 4'd15, dc, bc, r, d, w);
        checks++; if (r !== 32'd15) begin errors++; $display("FAIL midreset_new_result: got %0d want 15", r); end
        checks++; if (dc !== 33 || d !== 4'd15) begin errors++; $display("FAIL midreset_new_timing: got cyc=%0d dr=%0d want 33/15", dc, d); end
    endtask

    initial begin
        test_reset();
        test_mullo();
        test_mul_wide();
        test_div();
        test_div_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
